// File: rtl/xotr_phase_sequencer.sv
// xotr_phase_sequencer: latches fetched opcodes, runs the XPT phase counter and arbitrates fetch/execute handshakes for the XOTR decoders
module xotr_phase_sequencer #(
  parameter int XPT_WIDTH = 5,
  parameter int OPCODE_WIDTH = 8,
  parameter logic [OPCODE_WIDTH-1:0] RESET_OPCODE = '0
) (
  input  logic                    clock,
  input  logic                    notReset,
  input  logic [OPCODE_WIDTH-1:0] Data,
  input  logic                    Latch_Opcode,
  input  logic                    Wait,
  input  logic                    PR_Reset_XPT,
  input  logic                    P2_Set_CM1,
  input  logic                    P2_Reset_XOTR,
  input  logic                    Pa_Ophd,
  output logic [XPT_WIDTH-1:0]    XPT,
  output logic [XPT_WIDTH-1:0]    notXPT,
  output logic [OPCODE_WIDTH-1:0] Source,
  output logic [OPCODE_WIDTH-1:0] notSource,
  output logic                    XOTR,
  output logic                    CM1,
  output logic                    Overrun,
  output logic                    Ignored_Latch
);
  logic                    accept;
  logic                    inc;
  logic                    xpt_max;
  logic [XPT_WIDTH-1:0]    xpt_nx;
  logic [OPCODE_WIDTH-1:0] src_nx;
  logic                    xotr_nx;
  logic                    cm1_nx;
  logic                    ovr_nx;
  logic                    ign_nx;
  // next-state: accept overrides every decoder strobe, PR_Reset_XPT overrides counting
  always_comb begin
    accept  = Latch_Opcode & (CM1 | Pa_Ophd);
    xpt_max = &XPT;
    inc     = XOTR & ~Wait & ~PR_Reset_XPT;
    xpt_nx  = (accept | PR_Reset_XPT) ? '0 : (inc & ~xpt_max) ? XPT + XPT_WIDTH'(1) : XPT;
    src_nx  = accept ? Data : Source;
    xotr_nx = accept | (XOTR & ~P2_Reset_XOTR);
    cm1_nx  = ~accept & (CM1 | P2_Set_CM1);
    ovr_nx  = Overrun | (~accept & inc & xpt_max);
    ign_nx  = Ignored_Latch | (Latch_Opcode & ~accept);
  end
  // true and complement registers load from the same next value so they never disagree
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      XPT           <= '0;
      notXPT        <= '1;
      Source        <= RESET_OPCODE;
      notSource     <= ~RESET_OPCODE;
      XOTR          <= 1'b0;
      CM1           <= 1'b1;
      Overrun       <= 1'b0;
      Ignored_Latch <= 1'b0;
    end else begin
      XPT           <= xpt_nx;
      notXPT        <= ~xpt_nx;
      Source        <= src_nx;
      notSource     <= ~src_nx;
      XOTR          <= xotr_nx;
      CM1           <= cm1_nx;
      Overrun       <= ovr_nx;
      Ignored_Latch <= ign_nx;
    end
  end
endmodule

// File: tb/tb_xotr_phase_sequencer.sv
// tb_xotr_phase_sequencer: scoreboard-driven scenario bench for xotr_phase_sequencer
module tb_xotr_phase_sequencer;
  logic       clock;
  logic       notReset;
  logic [7:0] Data;
  logic       Latch_Opcode, Wait, PR_Reset_XPT, P2_Set_CM1, P2_Reset_XOTR, Pa_Ophd;
  logic [4:0] XPT, notXPT;
  logic [7:0] Source, notSource;
  logic       XOTR, CM1, Overrun, Ignored_Latch;

  xotr_phase_sequencer dut (
    .clock(clock), .notReset(notReset), .Data(Data), .Latch_Opcode(Latch_Opcode),
    .Wait(Wait), .PR_Reset_XPT(PR_Reset_XPT), .P2_Set_CM1(P2_Set_CM1),
    .P2_Reset_XOTR(P2_Reset_XOTR), .Pa_Ophd(Pa_Ophd), .XPT(XPT), .notXPT(notXPT),
    .Source(Source), .notSource(notSource), .XOTR(XOTR), .CM1(CM1),
    .Overrun(Overrun), .Ignored_Latch(Ignored_Latch)
  );

  localparam logic [5:0] LAT = 6'b100000, WT = 6'b010000, PRX = 6'b001000;
  localparam logic [5:0] SCM = 6'b000100, RXO = 6'b000010, PA = 6'b000001;
  localparam logic [29:0] ALL = '1;
  localparam logic [29:0] NOX = {10'b0, 20'hFFFFF};

  typedef struct {string n; logic [29:0] v; logic [29:0] m;} exp_t;
  exp_t sb[$];
  exp_t e;
  int total = 0;
  int bad = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [29:0] snap();
    return {XPT, notXPT, Source, notSource, XOTR, CM1, Overrun, Ignored_Latch};
  endfunction

  function automatic logic [29:0] ev(input logic [4:0] x, input logic [7:0] s,
                                     input logic xo, input logic c, input logic o, input logic i);
    return {x, ~x, s, ~s, xo, c, o, i};
  endfunction

  task automatic drive(input logic [5:0] c, input logic [7:0] d);
    {Latch_Opcode, Wait, PR_Reset_XPT, P2_Set_CM1, P2_Reset_XOTR, Pa_Ophd} = c;
    Data = d;
    @(posedge clock);
    #1;
    {Latch_Opcode, Wait, PR_Reset_XPT, P2_Set_CM1, P2_Reset_XOTR, Pa_Ophd} = '0;
    Data = '0;
  endtask

  task automatic test_reset();
    notReset = 1'b0;
    {Latch_Opcode, Wait, PR_Reset_XPT, P2_Set_CM1, P2_Reset_XOTR, Pa_Ophd} = '0;
    Data = '0;
    #12;
    sb.push_back('{"reset", ev(5'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0), ALL});
    e = sb.pop_front();
    total++;
    if ((snap() & e.m) !== (e.v & e.m)) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", e.n, snap() & e.m, e.v & e.m);
    end
    @(negedge clock);
    notReset = 1'b1;
  endtask

  task automatic test_fetch();
    sb.push_back('{"fetch_76", ev(5'd0, 8'h76, 1'b1, 1'b0, 1'b0, 1'b0), ALL});
    drive(LAT, 8'h76);
    e = sb.pop_front();
    total++;
    if ((snap() & e.m) !== (e.v & e.m)) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", e.n, snap() & e.m, e.v & e.m);
    end
  endtask

  task automatic test_count_wait();
    logic [5:0] c [6] = '{6'b0, 6'b0, 6'b0, WT, WT, WT | PRX};
    logic [4:0] x [6] = '{5'd1, 5'd2, 5'd3, 5'd3, 5'd3, 5'd0};
    for (int k = 0; k < 6; k++) begin
      sb.push_back('{$sformatf("count_%0d", k), ev(x[k], 8'h76, 1'b1, 1'b0, 1'b0, 1'b0), ALL});
      drive(c[k], 8'hEE);
      e = sb.pop_front();
      total++;
      if ((snap() & e.m) !== (e.v & e.m)) begin
        bad++;
        $display("FAIL %s: got=%h want=%h", e.n, snap() & e.m, e.v & e.m);
      end
    end
  endtask

  task automatic test_overlap();
    sb.push_back('{"count_1", ev(5'd1, 8'h76, 1'b1, 1'b0, 1'b0, 1'b0), ALL});
    sb.push_back('{"overlap_c9", ev(5'd0, 8'hC9, 1'b1, 1'b0, 1'b0, 1'b0), ALL});
    for (int k = 0; k < 2; k++) begin
      if (k == 0) drive(6'b0, 8'h00);
      else drive(LAT | PRX | SCM | RXO | PA, 8'hC9);
      e = sb.pop_front();
      total++;
      if ((snap() & e.m) !== (e.v & e.m)) begin
        bad++;
        $display("FAIL %s: got=%h want=%h", e.n, snap() & e.m, e.v & e.m);
      end
    end
  endtask

  task automatic test_all_strobes();
    sb.push_back('{"all_strobes", ev(5'd0, 8'hC9, 1'b0, 1'b1, 1'b0, 1'b0), ALL});
    sb.push_back('{"idle_hold", ev(5'd0, 8'hC9, 1'b0, 1'b1, 1'b0, 1'b0), ALL});
    sb.push_back('{"fetch_00", ev(5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0), ALL});
    for (int k = 0; k < 3; k++) begin
      if (k == 0) drive(PRX | SCM | RXO | PA, 8'h00);
      else if (k == 1) drive(6'b0, 8'h11);
      else drive(LAT, 8'h00);
      e = sb.pop_front();
      total++;
      if ((snap() & e.m) !== (e.v & e.m)) begin
        bad++;
        $display("FAIL %s: got=%h want=%h", e.n, snap() & e.m, e.v & e.m);
      end
    end
  endtask

  task automatic test_ignored_overrun();
    sb.push_back('{"ignored_55", ev(5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1), NOX});
    drive(LAT, 8'h55);
    e = sb.pop_front();
    total++;
    if ((snap() & e.m) !== (e.v & e.m)) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", e.n, snap() & e.m, e.v & e.m);
    end
    sb.push_back('{"saturate", ev(5'h1F, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1), ALL});
    repeat (40) drive(6'b0, 8'h00);
    e = sb.pop_front();
    total++;
    if ((snap() & e.m) !== (e.v & e.m)) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", e.n, snap() & e.m, e.v & e.m);
    end
  endtask

  task automatic test_async_reset();
    sb.push_back('{"rearm", ev(5'd0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1), ALL});
    sb.push_back('{"refetch_76", ev(5'd0, 8'h76, 1'b1, 1'b0, 1'b1, 1'b1), ALL});
    sb.push_back('{"count_7", ev(5'd7, 8'h76, 1'b1, 1'b0, 1'b1, 1'b1), ALL});
    drive(PRX | SCM, 8'h00);
    e = sb.pop_front();
    total++;
    if ((snap() & e.m) !== (e.v & e.m)) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", e.n, snap() & e.m, e.v & e.m);
    end
    drive(LAT, 8'h76);
    e = sb.pop_front();
    total++;
    if ((snap() & e.m) !== (e.v & e.m)) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", e.n, snap() & e.m, e.v & e.m);
    end
    repeat (7) drive(6'b0, 8'h00);
    e = sb.pop_front();
    total++;
    if ((snap() & e.m) !== (e.v & e.m)) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", e.n, snap() & e.m, e.v & e.m);
    end
    sb.push_back('{"async_reset", ev(5'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0), ALL});
    #1;
    notReset = 1'b0;
    #1;
    e = sb.pop_front();
    total++;
    if ((snap() & e.m) !== (e.v & e.m)) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", e.n, snap() & e.m, e.v & e.m);
    end
    @(negedge clock);
    notReset = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [5:0] c [3] = '{LAT, LAT, LAT | PA};
    logic [7:0] d [3] = '{8'hA5, 8'h3C, 8'h3C};
    sb.push_back('{"b2b_a5", ev(5'd0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0), ALL});
    sb.push_back('{"b2b_drop", ev(5'd0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1), NOX});
    sb.push_back('{"b2b_ophd", ev(5'd0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1), ALL});
    for (int k = 0; k < 3; k++) begin
      drive(c[k], d[k]);
      e = sb.pop_front();
      total++;
      if ((snap() & e.m) !== (e.v & e.m)) begin
        bad++;
        $display("FAIL %s: got=%h want=%h", e.n, snap() & e.m, e.v & e.m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_count_wait();
    test_overlap();
    test_all_strobes();
    test_ignored_overrun();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/xotr_phase_sequencer.md
Name: xotr_phase_sequencer

Overview:
- Upstream stage of the XOTR opcode decoders.
- Latches each fetched opcode into Source/notSource and raises the XOTR enable.
- Runs the XPT phase counter (XPT/notXPT) that the decoders compare against.
- Consumes the decoders' completion strobes (PR_Reset_XPT, P2_Set_CM1, P2_Reset_XOTR, Pa_Ophd) to end an instruction and re-arm the next opcode fetch (CM1).

Parameters:
XPT_WIDTH, 5, width of the phase counter; saturates at 2^XPT_WIDTH-1
OPCODE_WIDTH, 8, width of the latched opcode
RESET_OPCODE, 8'h00, Source value after reset

Ports:
clock  in  1  rising-edge clock
notReset  in  1  asynchronous, active-low reset
Data  in  OPCODE_WIDTH  opcode byte from the bus during a fetch
Latch_Opcode  in  1  one-cycle strobe: Data is valid for an opcode fetch
Wait  in  1  stall; freezes XPT advance only
PR_Reset_XPT  in  1  decoder strobe: clear XPT
P2_Set_CM1  in  1  decoder strobe: request next opcode fetch
P2_Reset_XOTR  in  1  decoder strobe: end XOTR execution
Pa_Ophd  in  1  decoder strobe: opcode handover, permits overlapped fetch
XPT  out  XPT_WIDTH  phase counter
notXPT  out  XPT_WIDTH  registered bitwise complement of XPT
Source  out  OPCODE_WIDTH  latched opcode
notSource  out  OPCODE_WIDTH  registered bitwise complement of Source
XOTR  out  1  execution enable to the decoders
CM1  out  1  fetch request (machine cycle 1 pending)
Overrun  out  1  sticky: XPT saturated
Ignored_Latch  out  1  sticky: Latch_Opcode dropped

Behaviour:
- Reset (notReset=0, asynchronous, takes effect immediately):
  - XPT=0, notXPT=all ones.
  - Source=RESET_OPCODE, notSource=~RESET_OPCODE.
  - XOTR=0, CM1=1, Overrun=0, Ignored_Latch=0.
- All state changes on the rising clock edge. All outputs are direct register outputs with no combinational input-to-output path.
- notXPT and notSource are separate registers, loaded on the same edge as their true counterparts. They are never anything other than the exact complement.
- Fetch acceptance: accept = Latch_Opcode & (CM1 | Pa_Ophd).
  - On accept: Source<=Data, XOTR<=1, CM1<=0, XPT<=0.
- Latch_Opcode with CM1=0 and Pa_Ophd=0:
  - Data is discarded and no state changes.
  - Ignored_Latch<=1, sticky until reset.
- Phase counting, only when there is no accept:
  - PR_Reset_XPT=1: XPT<=0. This applies regardless of Wait.
  - Otherwise, if XOTR=1 and Wait=0: XPT<=XPT+1.
  - At all ones, XPT holds (no wrap) and Overrun<=1, sticky until reset.
  - XOTR=0: XPT holds.
- Control strobes, only when there is no accept:
  - P2_Set_CM1=1: CM1<=1.
  - P2_Reset_XOTR=1: XOTR<=0. No effect if XOTR is already 0.
- Priority, highest first:
  1. reset
  2. accept
  3. PR_Reset_XPT
  4. increment
- Simultaneous events:
  - accept together with P2_Reset_XOTR/P2_Set_CM1/PR_Reset_XPT: the accept result wins (XOTR=1, CM1=0, XPT=0). The strobes are consumed.
  - All four decoder strobes together, no Latch_Opcode: XPT=0, CM1=1, XOTR=0.
  - Wait=1 with PR_Reset_XPT=1: XPT clears.
- Latency:
  - Source/XOTR are valid on the edge after accept. The decoders see XPT=0 in that first cycle.
  - A strobe from the decoders affects XPT/XOTR/CM1 one cycle later.
- Reset mid-instruction: everything returns to reset values asynchronously. Sticky flags clear.

Test Plan:
- Reset release, Latch_Opcode=1 with Data=8'h76 -> next edge: Source=76, notSource=89, XOTR=1, CM1=0, XPT=0, notXPT=1F.
- XOTR=1, 3 cycles with Wait=0 then 2 cycles with Wait=1 -> XPT=3 and held at 3; then PR_Reset_XPT with Wait=1 -> XPT=0.
- Latch_Opcode Data=8'hC9 with Pa_Ophd=P2_Set_CM1=P2_Reset_XOTR=PR_Reset_XPT=1 in the same cycle -> Source=C9, XOTR=1, CM1=0, XPT=0.
- All four strobes asserted, no Latch_Opcode -> XPT=0, XOTR=0, CM1=1; a following Latch_Opcode with Data=8'h00 is accepted.
- Latch_Opcode with Data=8'h55 while CM1=0 and Pa_Ophd=0 -> Source unchanged, Ignored_Latch=1; 40 free-running cycles -> XPT=1F held, Overrun=1.
- notReset pulsed low mid-count (XPT=7) without a clock edge -> XPT=0, CM1=1, XOTR=0, both sticky flags=0 immediately.
